// File: rtl/idct_mac_unit.sv
// Serial 8-tap multiply-accumulate producing one 1-D IDCT spatial sample x[n].
// Latency: out_valid rises 3 edges after the accept edge of X[7]; minimum 12-cycle block period.
// Backpressure: in_ready drops after X[7] until the output handshake; dout/out_valid hold while out_ready=0.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   pos_n               output index n, latched with coefficient k=0
//   in_valid/in_ready   coefficient handshake, coef_in carries X[k] for k=0..7 in order
//   out_valid/out_ready sample handshake, dout carries the saturated x[n]
module idct_mac_unit #(
  parameter int DIN_W  = 12,
  parameter int DOUT_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               pos_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DIN_W-1:0]  coef_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DOUT_W-1:0] dout
);

  localparam int PROD_W = DIN_W + 13;
  localparam int ACC_W  = DIN_W + 16;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  // Half an LSB of the Q12 result, added before the flooring shift.
  localparam logic signed [ACC_W-1:0] RND_C   = ACC_W'(2048);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DOUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DOUT_W - 1)));

  // Q12 cosine constants K[n][k] = round(4096 * C(k)/2 * cos((2n+1)k*pi/16)).
  // Every k=0 entry is 1448 (the 1/sqrt(2) DC weight) and is covered by the default.
  function automatic logic signed [12:0] krom(input logic [2:0] n, input logic [2:0] k);
    logic signed [12:0] v;
    case ({n, k})
      6'o01: v =  13'sd2009;  6'o02: v =  13'sd1892;  6'o03: v =  13'sd1703;
      6'o04: v =  13'sd1448;  6'o05: v =  13'sd1138;  6'o06: v =  13'sd784;
      6'o07: v =  13'sd400;
      6'o11: v =  13'sd1703;  6'o12: v =  13'sd784;   6'o13: v = -13'sd400;
      6'o14: v = -13'sd1448;  6'o15: v = -13'sd2009;  6'o16: v = -13'sd1892;
      6'o17: v = -13'sd1138;
      6'o21: v =  13'sd1138;  6'o22: v = -13'sd784;   6'o23: v = -13'sd2009;
      6'o24: v = -13'sd1448;  6'o25: v =  13'sd400;   6'o26: v =  13'sd1892;
      6'o27: v =  13'sd1703;
      6'o31: v =  13'sd400;   6'o32: v = -13'sd1892;  6'o33: v = -13'sd1138;
      6'o34: v =  13'sd1448;  6'o35: v =  13'sd1703;  6'o36: v = -13'sd784;
      6'o37: v = -13'sd2009;
      6'o41: v = -13'sd400;   6'o42: v = -13'sd1892;  6'o43: v =  13'sd1138;
      6'o44: v =  13'sd1448;  6'o45: v = -13'sd1703;  6'o46: v = -13'sd784;
      6'o47: v =  13'sd2009;
      6'o51: v = -13'sd1138;  6'o52: v = -13'sd784;   6'o53: v =  13'sd2009;
      6'o54: v = -13'sd1448;  6'o55: v = -13'sd400;   6'o56: v =  13'sd1892;
      6'o57: v = -13'sd1703;
      6'o61: v = -13'sd1703;  6'o62: v =  13'sd784;   6'o63: v =  13'sd400;
      6'o64: v = -13'sd1448;  6'o65: v =  13'sd2009;  6'o66: v = -13'sd1892;
      6'o67: v =  13'sd1138;
      6'o71: v = -13'sd2009;  6'o72: v =  13'sd1892;  6'o73: v = -13'sd1703;
      6'o74: v =  13'sd1448;  6'o75: v = -13'sd1138;  6'o76: v =  13'sd784;
      6'o77: v = -13'sd400;
      default: v = 13'sd1448;
    endcase
    return v;
  endfunction

  logic [1:0]               state;
  logic [2:0]               k_cnt;
  logic [2:0]               n_q;
  logic [1:0]               fl_cnt;

  // Stage 1: captured coefficient and its index, valid only on the cycle after an accept.
  logic                     s1_vld;
  logic signed [DIN_W-1:0]  x_q;
  logic [2:0]               kx_q;

  logic signed [PROD_W-1:0] mult_res;
  logic signed [ACC_W-1:0]  acc;

  logic                     out_valid_q;
  logic signed [DOUT_W-1:0] dout_q;

  logic                     accept;
  logic signed [12:0]       kval;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shr;
  logic signed [DOUT_W-1:0] sat_val;

  // in_ready depends on state only, so no combinational path from out_ready.
  assign in_ready  = (state == ST_ACC);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

  // n_q already holds the latched index when the k=0 product is formed one edge later.
  assign kval = krom(n_q, kx_q);
  assign prod = PROD_W'(x_q) * PROD_W'(kval);

  // Round half up then floor-shift out the Q12 fraction, clamp to the output range.
  always_comb begin
    rnd     = acc + RND_C;
    shr     = rnd >>> 12;
    sat_val = shr[DOUT_W-1:0];
    if (shr > SAT_MAX) begin
      sat_val = SAT_MAX[DOUT_W-1:0];
    end else if (shr < SAT_MIN) begin
      sat_val = SAT_MIN[DOUT_W-1:0];
    end
  end

  // Multiply / accumulate pipeline. Idle cycles push a zero product, so input
  // gaps neither stall nor double-count products already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      x_q      <= '0;
      kx_q     <= '0;
      n_q      <= '0;
      mult_res <= '0;
      acc      <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        x_q  <= coef_in;
        kx_q <= k_cnt;
        if (k_cnt == 3'd0) begin
          n_q <= pos_n;
        end
      end
      mult_res <= s1_vld ? prod : '0;
      if (state == ST_OUT && out_ready) begin
        acc <= '0;
      end else begin
        acc <= acc + ACC_W'(mult_res);
      end
    end
  end

  // Block sequencing: ACC (take 8 coefficients) -> FLUSH (drain 2 cycles) -> OUT (hold until taken).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACC;
      k_cnt       <= '0;
      fl_cnt      <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            k_cnt <= k_cnt + 3'd1;
            if (k_cnt == 3'd7) begin
              state  <= ST_FLUSH;
              fl_cnt <= '0;
            end
          end
        end
        ST_FLUSH: begin
          // The final product lands in acc two edges after the last accept.
          if (fl_cnt == 2'd2) begin
            dout_q      <= sat_val;
            out_valid_q <= 1'b1;
            state       <= ST_OUT;
          end else begin
            fl_cnt <= fl_cnt + 2'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            k_cnt       <= '0;
            state       <= ST_ACC;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idct_mac_unit.sv
module tb_idct_mac_unit;
  localparam int DIN_W  = 12;
  localparam int DOUT_W = 12;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [2:0]               pos_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIN_W-1:0]  coef_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DOUT_W-1:0] dout;

  idct_mac_unit #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pos_n     (pos_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_in   (coef_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int e7_cyc = 0;
  int n_hs   = 0;
  int exp_q[$];
  logic signed [DIN_W-1:0] blk [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every presented output that will be taken is scored against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d, expected none", int'(dout));
      end else begin
        chk("dout", int'(dout), exp_q.pop_front());
      end
      n_hs++;
    end
  end

  task automatic set_blk(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7);
    blk[0] = DIN_W'(a0); blk[1] = DIN_W'(a1); blk[2] = DIN_W'(a2); blk[3] = DIN_W'(a3);
    blk[4] = DIN_W'(a4); blk[5] = DIN_W'(a5); blk[6] = DIN_W'(a6); blk[7] = DIN_W'(a7);
  endtask

  // Drives the first nk coefficients of blk. Entered and left #1 after a rising edge.
  task automatic send(input logic [2:0] n, input int nk, input bit sparse);
    int   k   = 0;
    int   tmo = 0;
    int   gap = 0;
    bit   v;
    logic rdy;
    while (k < nk && tmo < 300) begin
      v = 1'b1;
      if (sparse && gap < 4) v = 1'($urandom_range(0, 1));
      gap      = v ? 0 : gap + 1;
      in_valid = v;
      coef_in  = v ? blk[k] : DIN_W'($urandom);
      pos_n    = (k == 0 || !sparse) ? n : 3'($urandom_range(0, 7));
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      tmo++;
      if (v && rdy) begin
        if (k == 7) e7_cyc = cyc;
        k++;
      end
    end
    in_valid = 1'b0;
    if (k < nk) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got %0d accepts, expected %0d", k, nk);
    end
  endtask

  task automatic wait_ov(input int bound);
    int t = 0;
    while (!out_valid && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", bound);
    end
  endtask

  // Waits until every queued result has been taken, then realigns to #1 after an edge.
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pos_n     = 3'd0;
    coef_in   = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dout", int'(dout), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // DC only: 1000*1448 = 1448000, (+2048)>>12 = 354
    set_blk(1000, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(354);
    send(3'd3, 8, 1'b0);
    @(negedge clk);
    chk("flush_in_ready", int'(in_ready), 0);
    wait_ov(20);
    chk("latency", cyc - e7_cyc, 3);
    @(negedge clk);
    chk("ov_pulse", int'(out_valid), 0);
    chk("ready_after_hs", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Negative rounding: 100*-2009 = -200900 -> floor(-198852/4096) = -49
    set_blk(0, 100, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(-49);
    send(3'd7, 8, 1'b0);
    drain();

    // Saturation high: 2047 * 10822 >> 12 far above 2047
    set_blk(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
    exp_q.push_back(2047);
    send(3'd0, 8, 1'b0);
    drain();

    // Saturation low under 10 cycles of backpressure
    set_blk(-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048);
    exp_q.push_back(-2048);
    out_ready = 1'b0;
    send(3'd0, 8, 1'b0);
    wait_ov(20);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_dout", int'(dout), -2048);
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_bp_in_ready", int'(in_ready), 1);
    chk("post_bp_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // Second block after backpressure: -1000*1448 -> -354
    set_blk(-1000, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(-354);
    send(3'd5, 8, 1'b0);
    drain();

    // n=2: 100*1448 + 50*1138 + (-30)*(-784) + 10*1703 = 242250 -> 59
    set_blk(100, 50, -30, 0, 0, 0, 0, 10);
    exp_q.push_back(59);
    send(3'd2, 8, 1'b0);
    drain();
    // Same block with valid gaps and pos_n wandering after k=0
    exp_q.push_back(59);
    send(3'd2, 8, 1'b1);
    drain();

    // Reset after 4 accepts discards the partial sum
    set_blk(500, 300, -200, 100, 0, 0, 0, 0);
    send(3'd3, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_dout", int'(dout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    set_blk(1000, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(354);
    send(3'd3, 8, 1'b0);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    chk("handshakes", n_hs, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idct_mac_unit.md
# idct_mac_unit

Sequential multiply-accumulate unit for the JPEG decoder's 1-D inverse DCT. It is the decode-side counterpart of the forward-DCT MAC unit in `fdct_zigzag.dct_mod`. It accepts the 8 coefficients X[0..7] of one row or column serially over a valid/ready handshake and multiplies each by a fixed cosine constant selected by output position n. It accumulates the products, then rounds, shifts and saturates the sum into one spatial sample x[n]. An 8-point 1-D IDCT pass instantiates eight of these, one per n.

## Interface
Parameters:
- `DIN_W`, 12: signed coefficient input width.
- `DOUT_W`, 12: signed sample output width; the result saturates to this range.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pos_n`  in  3  output index n; sampled with coefficient k=0 and held for the whole block.
- `in_valid`  in  1  a coefficient is present on `coef_in`.
- `in_ready`  out  1  the unit accepts a coefficient this cycle.
- `coef_in`  in  DIN_W  signed X[k], presented in order k=0..7.
- `out_valid`  out  1  `dout` holds a finished sample.
- `out_ready`  in  1  downstream accepts `dout`.
- `dout`  out  DOUT_W  signed x[n].

## Operation
- Constant ROM: K[n][k] = round(4096 · C(k)/2 · cos((2n+1)kπ/16)), with C(0)=1/√2 and C(k>0)=1.
  - 13-bit signed, Q12 format, rounded half away from zero.
  - n=0 row is 1448, 2009, 1892, 1703, 1448, 1138, 784, 400.
- Datapath widths:
  - `mult_res` is a DIN_W+13 bit signed register.
  - The accumulator is DIN_W+16 bits signed and never overflows.
- Output computation: sum = acc + 2048, arithmetically shifted right by 12 (floor), then clamped to [−2^(DOUT_W−1), 2^(DOUT_W−1)−1].
- The FSM has three states:
  - ACC: `in_ready`=1 and a 3-bit counter k counts accepted coefficients. On the 8th accept (k=7), go to FLUSH.
  - FLUSH: `in_ready`=0. Wait 2 cycles for the pipeline to drain, then load `dout`, set `out_valid`=1 and go to OUT.
  - OUT: `in_ready`=0 and `out_valid`=1. On `out_valid`&&`out_ready`, clear `out_valid`, the accumulator and k, then go to ACC.
- Accept rule: a coefficient is accepted only on an edge where `in_valid`&&`in_ready`. With `in_valid` low, k and the accumulator hold.
- `pos_n` is latched on the k=0 accept. Changes to `pos_n` during k=1..7 are ignored.
- `dout` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0.
- Reset values, forced asynchronously on `rst_n` low:
  - state=ACC, k=0;
  - `mult_res`, accumulator and latched n all 0;
  - `dout`=0, `out_valid`=0, `in_ready`=1 once `rst_n` is high.
- Reset mid-block discards the partial sum. The next accepted coefficient is treated as k=0.

## Timing
- Edge E: coefficient k is accepted.
- Edge E+1: `mult_res` = X[k]·K[n][k].
- Edge E+2: accumulator += `mult_res`.
- Latency: `out_valid` rises at edge E7+3, where E7 is the accept edge of X[7].
- `in_ready` is 0 from the cycle after E7 until the cycle after the output handshake edge.
- The output handshake edge itself returns the state to ACC, so `in_ready`=1 in the following cycle.
- Minimum block period is 12 cycles: 8 accepts, 3 pipeline cycles, 1 handshake.
- `in_ready` is a function of state only and has no combinational path from `out_ready`.
- `in_valid` gaps stall the counter but do not corrupt the sum. Products already in flight still accumulate correctly.

## Test plan
- DC only: n=3, X=[1000,0,0,0,0,0,0,0], `out_ready`=1 → `dout`=354. `out_valid` rises exactly 3 cycles after the X[7] accept and lasts 1 cycle.
- Negative rounding: n=7, X[1]=100, all others 0 (K=−2009) → `dout`=−49.
- Saturation: n=0 with all X=2047 → `dout`=2047. Then n=0 with all X=−2048 → `dout`=−2048.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` rises. Require:
  - `dout` and `out_valid` stable throughout;
  - `in_ready`=0 throughout;
  - after `out_ready`=1, `in_ready`=1 on the next cycle and a second block (X[0]=−1000, n=5) gives −354.
- Sparse input: toggle `in_valid` randomly, change `pos_n` during k=1..7 → same result as the unstalled block with n as latched at k=0.
- Reset mid-block: assert `rst_n`=0 after 4 accepts. Require all outputs at reset values immediately. A fresh DC block (X[0]=1000) then yields 354.
